// File: rtl/fp_compare_pipe.sv
// Pipelined sign-magnitude floating-point comparator (EQ/LT/LE/GT/GE/NE), latency STAGES (1..3).
// Define FPCMP_MINMAX_EN to add the pipelined minNum/maxNum outputs out_min/out_max.
module fp_compare_pipe #(
    parameter int unsigned WE     = 11,
    parameter int unsigned WF     = 15,
    parameter int unsigned STAGES = 2,
    localparam int unsigned W     = WE + WF + 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [2:0]   in_op,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    output logic         out_valid,
    output logic         out_result,
    output logic         out_unordered
`ifdef FPCMP_MINMAX_EN
    ,
    output logic [W-1:0] out_min,
    output logic [W-1:0] out_max
`endif
);

    localparam int unsigned HW = WE + 2;
    localparam int unsigned DW = 9;

    localparam logic [2:0] OP_EQ = 3'd0;
    localparam logic [2:0] OP_LT = 3'd1;
    localparam logic [2:0] OP_LE = 3'd2;
    localparam logic [2:0] OP_GT = 3'd3;
    localparam logic [2:0] OP_GE = 3'd4;
    localparam logic [2:0] OP_NE = 3'd5;

    // Operand decode: magnitude key split into {exc, exp} and frac, payload masked for zero/inf
    logic [1:0]    exc_a, exc_b;
    logic [HW-1:0] hi_a, hi_b;
    logic [WF-1:0] lo_a, lo_b;
    logic          s0_hi_eq, s0_hi_lt, s0_lo_eq, s0_lo_lt;
    logic [DW-1:0] s0_dec;

    assign exc_a = inA[W-1:W-2];
    assign exc_b = inB[W-1:W-2];
    assign hi_a  = {exc_a, exc_a[0] ? inA[WE+WF-1:WF] : WE'(0)};
    assign hi_b  = {exc_b, exc_b[0] ? inB[WE+WF-1:WF] : WE'(0)};
    assign lo_a  = exc_a[0] ? inA[WF-1:0] : WF'(0);
    assign lo_b  = exc_b[0] ? inB[WF-1:0] : WF'(0);

    assign s0_hi_eq = (hi_a == hi_b);
    assign s0_hi_lt = (hi_a <  hi_b);
    assign s0_lo_eq = (lo_a == lo_b);
    assign s0_lo_lt = (lo_a <  lo_b);

    // {op, nan_a, nan_b, zero_a, zero_b, sign_a, sign_b}
    assign s0_dec = {in_op, &exc_a, &exc_b, (exc_a == 2'b00), (exc_b == 2'b00),
                     inA[W-3], inB[W-3]};

    // Inputs to the result-forming stage
    logic          f_valid;
    logic [DW-1:0] f_dec;
    logic          f_mag_eq, f_mag_lt;
`ifdef FPCMP_MINMAX_EN
    logic [W-1:0]  f_a, f_b;
`endif

    if (STAGES == 1) begin : g_st1
        assign f_valid  = in_valid;
        assign f_dec    = s0_dec;
        assign f_mag_eq = s0_hi_eq & s0_lo_eq;
        assign f_mag_lt = s0_hi_lt | (s0_hi_eq & s0_lo_lt);
`ifdef FPCMP_MINMAX_EN
        assign f_a = inA;
        assign f_b = inB;
`endif
    end else if (STAGES == 2) begin : g_st2
        logic          p1_valid_q;
        logic [DW-1:0] p1_dec_q;
        logic          p1_mag_eq_q, p1_mag_lt_q;
`ifdef FPCMP_MINMAX_EN
        logic [W-1:0]  p1_a_q, p1_b_q;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) p1_valid_q <= 1'b0;
            else     p1_valid_q <= in_valid;
        end

        always_ff @(posedge clk) begin
            p1_dec_q    <= s0_dec;
            p1_mag_eq_q <= s0_hi_eq & s0_lo_eq;
            p1_mag_lt_q <= s0_hi_lt | (s0_hi_eq & s0_lo_lt);
`ifdef FPCMP_MINMAX_EN
            p1_a_q      <= inA;
            p1_b_q      <= inB;
`endif
        end

        assign f_valid  = p1_valid_q;
        assign f_dec    = p1_dec_q;
        assign f_mag_eq = p1_mag_eq_q;
        assign f_mag_lt = p1_mag_lt_q;
`ifdef FPCMP_MINMAX_EN
        assign f_a = p1_a_q;
        assign f_b = p1_b_q;
`endif
    end else begin : g_st3
        logic          p1_valid_q, p2_valid_q;
        logic [DW-1:0] p1_dec_q, p2_dec_q;
        logic          p1_hi_eq_q, p1_hi_lt_q, p1_lo_eq_q, p1_lo_lt_q;
        logic          p2_mag_eq_q, p2_mag_lt_q;
`ifdef FPCMP_MINMAX_EN
        logic [W-1:0]  p1_a_q, p1_b_q, p2_a_q, p2_b_q;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                p1_valid_q <= 1'b0;
                p2_valid_q <= 1'b0;
            end else begin
                p1_valid_q <= in_valid;
                p2_valid_q <= p1_valid_q;
            end
        end

        // Halves registered separately in stage 1, merged into one magnitude compare in stage 2
        always_ff @(posedge clk) begin
            p1_dec_q    <= s0_dec;
            p1_hi_eq_q  <= s0_hi_eq;
            p1_hi_lt_q  <= s0_hi_lt;
            p1_lo_eq_q  <= s0_lo_eq;
            p1_lo_lt_q  <= s0_lo_lt;
            p2_dec_q    <= p1_dec_q;
            p2_mag_eq_q <= p1_hi_eq_q & p1_lo_eq_q;
            p2_mag_lt_q <= p1_hi_lt_q | (p1_hi_eq_q & p1_lo_lt_q);
`ifdef FPCMP_MINMAX_EN
            p1_a_q      <= inA;
            p1_b_q      <= inB;
            p2_a_q      <= p1_a_q;
            p2_b_q      <= p1_b_q;
`endif
        end

        assign f_valid  = p2_valid_q;
        assign f_dec    = p2_dec_q;
        assign f_mag_eq = p2_mag_eq_q;
        assign f_mag_lt = p2_mag_lt_q;
`ifdef FPCMP_MINMAX_EN
        assign f_a = p2_a_q;
        assign f_b = p2_b_q;
`endif
    end

    logic [2:0] f_op;
    logic       f_nan_a, f_nan_b, f_zero_a, f_zero_b, f_sign_a, f_sign_b;
    logic       f_unord, f_eq, f_lt, f_res;

    assign f_op     = f_dec[8:6];
    assign f_nan_a  = f_dec[5];
    assign f_nan_b  = f_dec[4];
    assign f_zero_a = f_dec[3];
    assign f_zero_b = f_dec[2];
    assign f_sign_a = f_dec[1];
    assign f_sign_b = f_dec[0];

    // Ordered relation from signs and magnitude; zero key is minimal so only +-0 vs +-0 needs care
    always_comb begin
        f_unord = f_nan_a | f_nan_b;
        f_eq    = 1'b0;
        f_lt    = 1'b0;
        f_res   = 1'b0;
        if (f_zero_a && f_zero_b) begin
            f_eq = 1'b1;
        end else if (f_sign_a != f_sign_b) begin
            f_lt = f_sign_a;
        end else if (!f_sign_a) begin
            f_eq = f_mag_eq;
            f_lt = f_mag_lt;
        end else begin
            f_eq = f_mag_eq;
            f_lt = !f_mag_lt && !f_mag_eq;
        end
        if (f_unord) begin
            f_res = (f_op == OP_NE);
        end else begin
            case (f_op)
                OP_EQ:   f_res = f_eq;
                OP_LT:   f_res = f_lt;
                OP_LE:   f_res = f_lt | f_eq;
                OP_GT:   f_res = !f_lt && !f_eq;
                OP_GE:   f_res = !f_lt;
                OP_NE:   f_res = !f_eq;
                default: f_res = 1'b0;
            endcase
        end
    end

`ifdef FPCMP_MINMAX_EN
    logic [W-1:0] f_min, f_max;

    always_comb begin
        f_min = f_a;
        f_max = f_a;
        if (f_nan_a && f_nan_b) begin
            f_min = {2'b11, (W-2)'(0)};
            f_max = {2'b11, (W-2)'(0)};
        end else if (f_nan_a) begin
            f_min = f_b;
            f_max = f_b;
        end else if (f_nan_b) begin
            f_min = f_a;
            f_max = f_a;
        end else if (f_zero_a && f_zero_b) begin
            f_min = f_sign_a ? f_a : f_b;
            f_max = f_sign_a ? f_b : f_a;
        end else begin
            f_min = (f_lt || f_eq) ? f_a : f_b;
            f_max = f_lt ? f_b : f_a;
        end
    end
`endif

    logic         valid_q, result_q, unord_q;
`ifdef FPCMP_MINMAX_EN
    logic [W-1:0] min_q, max_q;
`endif

    // Result registers hold their value across bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= 1'b0;
            unord_q  <= 1'b0;
`ifdef FPCMP_MINMAX_EN
            min_q    <= '0;
            max_q    <= '0;
`endif
        end else begin
            valid_q <= f_valid;
            if (f_valid) begin
                result_q <= f_res;
                unord_q  <= f_unord;
`ifdef FPCMP_MINMAX_EN
                min_q    <= f_min;
                max_q    <= f_max;
`endif
            end
        end
    end

    assign out_valid     = valid_q;
    assign out_result    = result_q;
    assign out_unordered = unord_q;
`ifdef FPCMP_MINMAX_EN
    assign out_min       = min_q;
    assign out_max       = max_q;
`endif

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Directed and random-stream bench for fp_compare_pipe; one instance per STAGES value 1..3
// driven with the same stimulus. Min/max checks are active when FPCMP_MINMAX_EN is defined.
module tb_fp_compare_pipe;

    localparam int unsigned WE = 11;
    localparam int unsigned WF = 15;
    localparam int unsigned W  = WE + WF + 3;

    localparam logic [2:0] OP_EQ = 3'd0;
    localparam logic [2:0] OP_LT = 3'd1;
    localparam logic [2:0] OP_LE = 3'd2;
    localparam logic [2:0] OP_GT = 3'd3;
    localparam logic [2:0] OP_GE = 3'd4;
    localparam logic [2:0] OP_NE = 3'd5;

    localparam logic [W-1:0] V_ONE   = 29'h09FF8000;
    localparam logic [W-1:0] V_TWO   = 29'h0A000000;
    localparam logic [W-1:0] V_MONE  = 29'h0DFF8000;
    localparam logic [W-1:0] V_MTWO  = 29'h0E000000;
    localparam logic [W-1:0] V_PZERO = 29'h00000000;
    localparam logic [W-1:0] V_MZERO = 29'h04000000;
    localparam logic [W-1:0] V_PINF  = 29'h10000000;
    localparam logic [W-1:0] V_INFPL = 29'h10000123;
    localparam logic [W-1:0] V_NAN   = 29'h18000000;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [2:0]   in_op;
    logic [W-1:0] inA, inB;
    logic [3:1]   ov, orr, ou;
`ifdef FPCMP_MINMAX_EN
    logic [W-1:0] omin [1:3];
    logic [W-1:0] omax [1:3];
`endif

    for (genvar g = 1; g <= 3; g++) begin : g_dut
        fp_compare_pipe #(.WE(WE), .WF(WF), .STAGES(g)) u_dut (
            .clk           (clk),
            .rst           (rst),
            .in_valid      (in_valid),
            .in_op         (in_op),
            .inA           (inA),
            .inB           (inB),
            .out_valid     (ov[g]),
            .out_result    (orr[g]),
            .out_unordered (ou[g])
`ifdef FPCMP_MINMAX_EN
            ,
            .out_min       (omin[g]),
            .out_max       (omax[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected-output history: index k = op sampled k edges ago; l* = last emitted value per STAGES
    logic hv [0:2];
    logic hr [0:2];
    logic hu [0:2];
    logic lr [1:3];
    logic lu [1:3];
`ifdef FPCMP_MINMAX_EN
    logic [W-1:0] hmin [0:2];
    logic [W-1:0] hmax [0:2];
    logic [W-1:0] lmin [1:3];
    logic [W-1:0] lmax [1:3];
`endif

    // Total-order ordinal of a non-NaN operand: zero 0, normals 1.., inf above all normals
    function automatic longint ord_of(input logic [W-1:0] x);
        longint m;
        case (x[W-1:W-2])
            2'b00:   m = 0;
            2'b01:   m = 1 + longint'(x[WE+WF-1:0]);
            2'b10:   m = (longint'(1) << (WE + WF)) + 1;
            default: m = 0;
        endcase
        return x[W-3] ? -m : m;
    endfunction

    function automatic logic is_nan(input logic [W-1:0] x);
        return x[W-1:W-2] == 2'b11;
    endfunction

    // Returns {unordered, result}
    function automatic logic [1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint oa, ob;
        logic r;
        if (is_nan(a) || is_nan(b)) return {1'b1, op == OP_NE};
        oa = ord_of(a);
        ob = ord_of(b);
        case (op)
            OP_EQ:   r = (oa == ob);
            OP_LT:   r = (oa <  ob);
            OP_LE:   r = (oa <= ob);
            OP_GT:   r = (oa >  ob);
            OP_GE:   r = (oa >= ob);
            OP_NE:   r = (oa != ob);
            default: r = 1'b0;
        endcase
        return {1'b0, r};
    endfunction

`ifdef FPCMP_MINMAX_EN
    // Returns {min, max}
    function automatic logic [2*W-1:0] model_mm(input logic [W-1:0] a, input logic [W-1:0] b);
        logic za, zb;
        if (is_nan(a) && is_nan(b)) return {V_NAN, V_NAN};
        if (is_nan(a)) return {b, b};
        if (is_nan(b)) return {a, a};
        za = (a[W-1:W-2] == 2'b00);
        zb = (b[W-1:W-2] == 2'b00);
        if (za && zb) return {(a[W-3] ? a : b), (!a[W-3] ? a : b)};
        return {((ord_of(a) <= ord_of(b)) ? a : b), ((ord_of(a) >= ord_of(b)) ? a : b)};
    endfunction
`endif

    function automatic logic [W-1:0] rand_operand();
        logic [1:0]    e;
        logic [WE-1:0] x;
        logic [WF-1:0] f;
        int unsigned   r;
        r = $urandom_range(0, 9);
        e = (r < 6) ? 2'b01 : 2'(r - 6);
        case ($urandom_range(0, 2))
            0:       x = WE'(11'h3FF);
            1:       x = WE'(11'h400);
            default: x = WE'($urandom);
        endcase
        f = ($urandom_range(0, 1) == 0) ? WF'(0) : WF'($urandom);
        return {e, 1'($urandom), x, f};
    endfunction

    task automatic clear_hist();
        for (int k = 0; k < 3; k++) begin
            hv[k] = 1'b0;
            hr[k] = 1'b0;
            hu[k] = 1'b0;
            lr[k+1] = 1'b0;
            lu[k+1] = 1'b0;
`ifdef FPCMP_MINMAX_EN
            hmin[k] = '0;
            hmax[k] = '0;
            lmin[k+1] = '0;
            lmax[k+1] = '0;
`endif
        end
    endtask

    // One clock: drive inputs, clock them in, check all three instances against the model
    task automatic cycle(input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [1:0] m;
        in_valid = v;
        in_op    = op;
        inA      = a;
        inB      = b;
        m = model(op, a, b);
        @(posedge clk);
        for (int k = 2; k >= 1; k--) begin
            hv[k] = hv[k-1];
            hr[k] = hr[k-1];
            hu[k] = hu[k-1];
`ifdef FPCMP_MINMAX_EN
            hmin[k] = hmin[k-1];
            hmax[k] = hmax[k-1];
`endif
        end
        hv[0] = v;
        hr[0] = m[0];
        hu[0] = m[1];
`ifdef FPCMP_MINMAX_EN
        {hmin[0], hmax[0]} = model_mm(a, b);
`endif
        #1;
        for (int s = 1; s <= 3; s++) begin
            if (hv[s-1]) begin
                lr[s] = hr[s-1];
                lu[s] = hu[s-1];
`ifdef FPCMP_MINMAX_EN
                lmin[s] = hmin[s-1];
                lmax[s] = hmax[s-1];
`endif
            end
            n_cmp++;
            assert (ov[s] === hv[s-1]) else begin
                n_bad++;
                $error("FAIL stream_valid S%0d: observed %b expected %b", s, ov[s], hv[s-1]);
            end
            n_cmp++;
            assert ({orr[s], ou[s]} === {lr[s], lu[s]}) else begin
                n_bad++;
                $error("FAIL stream_result S%0d: observed r=%b u=%b expected r=%b u=%b",
                       s, orr[s], ou[s], lr[s], lu[s]);
            end
`ifdef FPCMP_MINMAX_EN
            n_cmp++;
            assert ({omin[s], omax[s]} === {lmin[s], lmax[s]}) else begin
                n_bad++;
                $error("FAIL stream_minmax S%0d: observed %h/%h expected %h/%h",
                       s, omin[s], omax[s], lmin[s], lmax[s]);
            end
`endif
        end
    endtask

    // Single op then a bubble; STAGES=2 instance must present the hand-computed result
    task automatic directed(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic er, input logic eu);
        cycle(1'b1, op, a, b);
        cycle(1'b0, OP_EQ, '0, '0);
        n_cmp++;
        assert ({ov[2], orr[2], ou[2]} === {1'b1, er, eu}) else begin
            n_bad++;
            $error("FAIL %s: observed v=%b r=%b u=%b expected v=1 r=%b u=%b",
                   tag, ov[2], orr[2], ou[2], er, eu);
        end
    endtask

`ifdef FPCMP_MINMAX_EN
    task automatic directed_mm(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] emin, input logic [W-1:0] emax);
        cycle(1'b1, OP_EQ, a, b);
        cycle(1'b0, OP_EQ, '0, '0);
        n_cmp++;
        assert ({omin[2], omax[2]} === {emin, emax}) else begin
            n_bad++;
            $error("FAIL %s: observed min=%h max=%h expected min=%h max=%h",
                   tag, omin[2], omax[2], emin, emax);
        end
    endtask
`endif

    task automatic check_zero(input string tag);
        for (int s = 1; s <= 3; s++) begin
            n_cmp++;
            assert ({ov[s], orr[s], ou[s]} === 3'b000) else begin
                n_bad++;
                $error("FAIL %s S%0d: observed v=%b r=%b u=%b expected all 0", tag, s, ov[s], orr[s], ou[s]);
            end
`ifdef FPCMP_MINMAX_EN
            n_cmp++;
            assert ({omin[s], omax[s]} === '0) else begin
                n_bad++;
                $error("FAIL %s_minmax S%0d: observed %h/%h expected 0/0", tag, s, omin[s], omax[s]);
            end
`endif
        end
    endtask

    initial begin
        logic [W-1:0] a, b;
        int unsigned  nops;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_op    = OP_EQ;
        inA      = '0;
        inB      = '0;
        clear_hist();
        #12;
        check_zero("reset_state");
        @(posedge clk);
        #1 rst = 1'b0;

        directed("le_1_2",      OP_LE, V_ONE,   V_TWO,   1'b1, 1'b0);
        directed("gt_1_2",      OP_GT, V_ONE,   V_TWO,   1'b0, 1'b0);
        directed("lt_m1_1",     OP_LT, V_MONE,  V_ONE,   1'b1, 1'b0);
        directed("eq_pz_mz",    OP_EQ, V_PZERO, V_MZERO, 1'b1, 1'b0);
        directed("lt_1_inf",    OP_LT, V_ONE,   V_PINF,  1'b1, 1'b0);
        directed("reserved6",   3'd6,  V_ONE,   V_ONE,   1'b0, 1'b0);
        directed("ne_nan_1",    OP_NE, V_NAN,   V_ONE,   1'b1, 1'b1);
        directed("le_nan_1",    OP_LE, V_NAN,   V_ONE,   1'b0, 1'b1);
        directed("eq_inf_pay",  OP_EQ, V_INFPL, V_PINF,  1'b1, 1'b0);
        directed("lt_m2_m1",    OP_LT, V_MTWO,  V_MONE,  1'b1, 1'b0);
        directed("ge_m1_m1",    OP_GE, V_MONE,  V_MONE,  1'b1, 1'b0);
        directed("gt_m1_mz",    OP_GT, V_MONE,  V_MZERO, 1'b0, 1'b0);
`ifdef FPCMP_MINMAX_EN
        directed_mm("mm_mz_pz",   V_MZERO, V_PZERO, V_MZERO, V_PZERO);
        directed_mm("mm_nan_2",   V_NAN,   V_TWO,   V_TWO,   V_TWO);
        directed_mm("mm_nan_nan", V_NAN,   V_NAN,   V_NAN,   V_NAN);
        directed_mm("mm_1_m2",    V_ONE,   V_MTWO,  V_MTWO,  V_ONE);
`endif

        // Random stream with gaps; every instance checked every cycle
        nops = 0;
        while (nops < 1000) begin
            if ($urandom_range(0, 3) == 0) begin
                cycle(1'b0, 3'($urandom), rand_operand(), rand_operand());
            end else begin
                a = rand_operand();
                case ($urandom_range(0, 3))
                    0:       b = rand_operand();
                    1:       b = a;
                    2:       b = a ^ W'(1);
                    default: b = a ^ (W'(1) << (W - 3));
                endcase
                cycle(1'b1, 3'($urandom), a, b);
                nops++;
            end
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, OP_EQ, '0, '0);

        // Reset mid-stream: in-flight ops discarded, outputs cleared at once
        cycle(1'b1, OP_LT, V_ONE, V_TWO);
        cycle(1'b1, OP_LT, V_MONE, V_ONE);
        in_op = OP_NE;
        inA   = V_NAN;
        rst   = 1'b1;
        #1;
        check_zero("reset_midstream");
        @(posedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        clear_hist();
        for (int k = 0; k < 5; k++) cycle(1'b0, OP_EQ, '0, '0);
        check_zero("reset_release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
